// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register-bank side blocks.
//   REG_ADDR_W   : register index width (32 registers)
//   REG_DATA_W   : register data width
//   dump_state_t : control states of the register dump reader
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Read-side initiator for the MIPS register bank. A start pulse walks an
// inclusive (possibly wrapping) range of register addresses on one bank read
// port and streams each (address, data) pair out over a valid/ready channel.
// It never writes the bank.
//
// Parameters
//   ADDR_W    : register address width (bank depth 2**ADDR_W)
//   DATA_W    : register data width
//   SKIP_ZERO : 1 = register 0 is never emitted
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   1-cycle dump request, honoured only while idle
//   first_addr in   first register of the range, sampled at start
//   last_addr  in   last register of the range, sampled at start
//   rf_addr    out  bank read address (0 when not walking)
//   rf_data    in   bank read data, combinational w.r.t. rf_addr
//   out_valid  out  out_addr/out_data hold a beat
//   out_ready  in   consumer accepts the beat on valid&ready at an edge
//   out_addr   out  register index of the current beat
//   out_data   out  register value of the current beat
//   busy       out  high while walking or draining the last beat
//   done       out  1-cycle pulse after the final beat is accepted
module regfile_dump_reader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DATA_W    = REG_DATA_W,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  dump_state_t       state_q;
  dump_state_t       state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] last_q;
  logic              load;
  logic              zero_beats;

  // Address following p in the walk; register 0 is stepped over when skipped.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] p);
    if (p == ADDR_MAX)
      next_addr = SKIP_ZERO ? ADDR_ONE : '0;
    else
      next_addr = p + ADDR_ONE;
  endfunction

  // Start address after applying the register-0 skip.
  function automatic logic [ADDR_W-1:0] start_addr(input logic [ADDR_W-1:0] a);
    start_addr = (SKIP_ZERO && (a == '0)) ? ADDR_ONE : a;
  endfunction

  // End address after applying the register-0 skip: a range ending on 0 really
  // ends on the highest register, otherwise the walk would never meet it.
  function automatic logic [ADDR_W-1:0] stop_addr(input logic [ADDR_W-1:0] a);
    stop_addr = (SKIP_ZERO && (a == '0)) ? ADDR_MAX : a;
  endfunction

  // Output register may take a new beat when empty or being emptied this edge.
  assign load = !out_valid || out_ready;

  // The only range that yields nothing: register 0 alone while it is skipped.
  assign zero_beats = SKIP_ZERO && (first_addr == '0) && (last_addr == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start)
          state_d = zero_beats ? DONE : RUN;
      end
      RUN: begin
        if (load && (ptr_q == last_q))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (out_valid && out_ready)
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control outputs
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    rf_addr = '0;
    case (state_q)
      RUN: begin
        busy    = 1'b1;
        rf_addr = ptr_q;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Walk pointer and output beat register. rf_data is captured at the same
  // edge a bank write might land, so the pre-write value is what streams out.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      last_q    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q  <= start_addr(first_addr);
            last_q <= stop_addr(last_addr);
          end
        end
        RUN: begin
          if (load) begin
            out_data  <= rf_data;
            out_addr  <= ptr_q;
            out_valid <= 1'b1;
            if (ptr_q != last_q)
              ptr_q <= next_addr(ptr_q);
          end
        end
        DRAIN: begin
          if (out_valid && out_ready)
            out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
